// File: rtl/uart_rx.sv
// UART receive front-end: 2-flop synchroniser, mid-bit sampling (LSB first), stop check, valid/ready holding register.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined (adds parity_err).
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 sync1_q, rxd_s_q, rxd_s_dly_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 stop_ok;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  wire cnt_zero = (cnt_q == '0);

  // Handshake: a byte moves when rx_valid and rx_ready are both 1 at a clk edge;
  // rx_data holds steady until then, and rx_ready is don't-care while rx_valid is 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    stop_ok     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rxd_s_dly_q && !rxd_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (!cnt_zero) cnt_d = cnt_q - CW'(1);
        else if (!rxd_s_q) begin
          state_d = S_DATA;
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
        end else state_d = S_IDLE;
      end
      S_DATA: begin
        if (!cnt_zero) cnt_d = cnt_q - CW'(1);
        else begin
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          idx_d   = idx_q + BW'(1);
          if (idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!cnt_zero) cnt_d = cnt_q - CW'(1);
        else begin
          par_d   = rxd_s_q;
          cnt_d   = FULL_LOAD;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!cnt_zero) cnt_d = cnt_q - CW'(1);
        else if (rxd_s_q) begin
          stop_ok = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh byte may replace the held one only if the held one is consumed in the same cycle.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (stop_ok) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
`ifdef UART_RX_PARITY_EN
    parity_err_d = stop_ok && ((^shift_q) ^ par_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_s_dly_q <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      sync1_q     <= rxd;
      rxd_s_q     <= sync1_q;
      rxd_s_dly_q <= rxd_s_q;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16, DATA_BITS=8; define UART_RX_PARITY_EN to add the parity scenario.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pe_cnt = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int valid_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Pre-edge values, i.e. exactly what the DUT sees at this edge.
  always @(posedge clk) begin
    if (rx_valid) valid_cyc++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    wait_cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit use_par, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par_b);
    drive_bit(stop_b);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; rxd = 1'b1; rx_ready = 1'b1;
    wait_cyc(3);
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    reset = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_basic_frame;
    int v0, f0, o0;
    v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    n_vec++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL t1_data: got %h expected a5", rx_data); end
    n_vec++; if (valid_cyc - v0 != 1) begin n_err++; $display("FAIL t1_valid_width: got %0d expected 1", valid_cyc - v0); end
    n_vec++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'hA5) begin n_err++; $display("FAIL t1_accepted: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
    n_vec++; if (fe_cnt != f0 || ov_cnt != o0) begin n_err++; $display("FAIL t1_errs: got fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cyc; f0 = fe_cnt;
    rxd = 1'b0; wait_cyc(4);
    rxd = 1'b1; wait_cyc(2);
    n_vec++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL t2_busy_start: got %b expected 1", rx_busy); end
    wait_cyc(7);
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL t2_busy_idle: got %b expected 0", rx_busy); end
    n_vec++; if (valid_cyc != v0 || fe_cnt != f0) begin n_err++; $display("FAIL t2_no_output: got valid=%0d fe=%0d expected 0 0", valid_cyc - v0, fe_cnt - f0); end
    wait_cyc(4);
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = valid_cyc; f0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h3C >> i));
    rxd = 1'b0; wait_cyc(30);
    n_vec++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL t3_busy_break: got %b expected 1", rx_busy); end
    wait_cyc(10);
    rxd = 1'b1; wait_cyc(6);
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL t3_busy_release: got %b expected 0", rx_busy); end
    n_vec++; if (fe_cnt - f0 != 1) begin n_err++; $display("FAIL t3_ferr_pulses: got %0d expected 1", fe_cnt - f0); end
    n_vec++; if (valid_cyc != v0) begin n_err++; $display("FAIL t3_no_valid: got %0d expected 0", valid_cyc - v0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    n_vec++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h81) begin n_err++; $display("FAIL t3_after_break: got %0d bytes expected %0d with 81", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int o0, n0;
    o0 = ov_cnt; n0 = got_q.size();
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL t4_valid_held: got %b expected 1", rx_valid); end
    n_vec++; if (rx_data !== 8'h55) begin n_err++; $display("FAIL t4_data_held: got %h expected 55", rx_data); end
    n_vec++; if (ov_cnt - o0 != 1) begin n_err++; $display("FAIL t4_overrun: got %0d expected 1", ov_cnt - o0); end
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    wait_cyc(1);
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL t4_valid_clear: got %b expected 0", rx_valid); end
    n_vec++; if (got_q.size() != n0 + 1 || got_q[$] !== 8'h55) begin n_err++; $display("FAIL t4_accepted: got %0d new bytes expected 1 of 55", got_q.size() - n0); end
    wait_cyc(2);
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    v0 = valid_cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hF0 >> i));
    rxd = 1'b1; wait_cyc(8);
    n_vec++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL t5_busy_before: got %b expected 1", rx_busy); end
    reset = 1'b0; wait_cyc(1);
    reset = 1'b1;
    n_vec++; if ({rx_valid, frame_err, overrun, rx_busy} !== 4'b0000) begin n_err++; $display("FAIL t5_flags: got %b expected 0000", {rx_valid, frame_err, overrun, rx_busy}); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL t5_data: got %h expected 00", rx_data); end
    wait_cyc(8 + 3 * CPB + CPB);
    n_vec++; if (valid_cyc != v0 || rx_busy !== 1'b0) begin n_err++; $display("FAIL t5_no_byte: got valid=%0d busy=%b expected 0 0", valid_cyc - v0, rx_busy); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    n_vec++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h12) begin n_err++; $display("FAIL t5_after_reset: got %0d bytes expected %0d with 12", got_q.size(), exp_q.size()); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int p0;
    p0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_cyc(4);
    n_vec++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h07) begin n_err++; $display("FAIL t6_good_data: got %0d bytes expected %0d with 07", got_q.size(), exp_q.size()); end
    n_vec++; if (pe_cnt != p0) begin n_err++; $display("FAIL t6_good_perr: got %0d expected 0", pe_cnt - p0); end
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_cyc(4);
    n_vec++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h07) begin n_err++; $display("FAIL t6_bad_data: got %0d bytes expected %0d with 07", got_q.size(), exp_q.size()); end
    n_vec++; if (pe_cnt - p0 != 1) begin n_err++; $display("FAIL t6_bad_perr: got %0d expected 1", pe_cnt - p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL sb_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL sb_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive front-end for the memory-mapped UART IO block. It synchronises the `rxd` pin, detects and validates start bits, and samples data bits at mid-bit, LSB first. It checks the stop bit and presents each received byte on a valid/ready handshake. The consumer is the RX FIFO write side, which in turn feeds system-bus reads from the UART address window.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); must be >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
rxd  input  1  asynchronous serial line; idle high
rx_data  output  DATA_BITS  received byte; valid while rx_valid=1
rx_valid  output  1  holding register contains an unconsumed byte
rx_ready  input  1  consumer accepts the byte (RX FIFO not full)
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte dropped because the holding register was still occupied
rx_busy  output  1  state machine not in IDLE

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0.
  - Bit counter, sample counter and shift register cleared.
  - Synchroniser flops set to 1.
  - Reset asserted mid-frame aborts the frame; no partial byte is ever presented.
- Synchroniser: 2 flops on rxd produce rxd_s; rxd_s_d is rxd_s delayed one cycle. All decisions use rxd_s.
- IDLE:
  - Falling edge (rxd_s_d=1, rxd_s=0) -> START; load the sample counter with CLKS_PER_BIT/2-1 (integer divide).
- START:
  - On counter expiry, sample rxd_s.
  - rxd_s=0 -> DATA, with the counter reloaded to CLKS_PER_BIT-1 and the bit index set to 0.
  - rxd_s=1 -> glitch: return to IDLE with no output.
- DATA:
  - Each expiry samples rxd_s into bit[index], LSB first, and reloads the counter.
  - After bit DATA_BITS-1 -> STOP (or PARITY, see Optional Feature).
- STOP:
  - On expiry, sample rxd_s.
  - 1 -> deliver the byte (below), then IDLE.
  - 0 -> frame_err=1 for exactly one cycle, byte discarded, then WAIT_IDLE.
- WAIT_IDLE: remain until rxd_s=1, then IDLE. This prevents a break condition from re-triggering a start.
- Delivery (the cycle after the stop-bit sample):
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: rx_data loads the new byte and rx_valid=1.
  - rx_valid=1 with rx_ready=0: new byte dropped, rx_data unchanged, overrun=1 for one cycle.
- Handshake:
  - A transfer occurs when rx_valid and rx_ready are both 1 at a clk edge. rx_valid clears next cycle unless a new delivery coincides.
  - rx_data is stable while rx_valid=1 and not accepted.
  - rx_ready is ignored while rx_valid=0.
- Latency: rx_valid rises 2 (sync) + 1 cycles after the stop-bit mid-point on rxd.
- rx_busy=1 in every state except IDLE.
- Counters sized $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1). There is no wrap-around beyond the reload values.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP, sampled at mid-bit.
  - Even parity: XOR of the data bits and the parity bit must be 0.
  - Adds output port parity_err (1 bit), a one-cycle pulse on mismatch, coincident with the delivery cycle.
  - The byte is still delivered and the stop check still applies. If both parity and framing fail, only frame_err pulses and no byte is delivered.
- Undefined: no PARITY state, no parity_err port, frame = start + DATA_BITS + stop.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
1. Drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with rx_ready=1 -> rx_data=0xA5, rx_valid high one cycle, frame_err=0, overrun=0.
2. Pulse rxd low for 4 cycles from idle -> START aborts at mid-bit; rx_valid, frame_err and rx_busy return to 0 by cycle 12.
3. Frame 0x3C with stop bit 0, held low 40 cycles, then high -> frame_err single pulse, no rx_valid. rx_busy stays 1 until rxd_s=1, then a following 0x81 is received correctly.
4. rx_ready=0; send 0x55 then 0x3C back-to-back -> rx_data=0x55 with rx_valid=1; overrun pulses once on the second frame; rx_data remains 0x55. Raising rx_ready then clears rx_valid next cycle.
5. Assert reset (0) during DATA bit 4 of 0xF0 for 1 cycle -> all outputs 0 next cycle, no byte delivered. A subsequent 0x12 is received correctly.
6. With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_data=0x07, parity_err=0. 0x07 with parity 0 -> byte delivered and parity_err pulses once.
